bram_uart_streamer: RTL and testbench

Transmit-side counterpart of the image receive path. On a start pulse it walks a frame buffer BRAM from address 0 to WIDTH*HEIGHT-1 and serialises each pixel as one 8N1 UART byte on tx_out, with no idle gap between bytes. It sits between a pyramid-level BRAM read port and the board UART TX pin, and returns frames to the host script.

---
 rtl/bram_uart_streamer.sv | 183 ++++++++++++++++++
 tb/tb_bram_uart_streamer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_uart_streamer.sv
// Streams a WIDTH*HEIGHT frame buffer from a BRAM read port out as back-to-back 8N1 UART bytes.
// Define BRAM_UART_STREAMER_CHECKSUM_EN to append a mod-256 sum of the frame as one extra byte.
module bram_uart_streamer #(
  parameter int unsigned WIDTH           = 64,
  parameter int unsigned HEIGHT          = 64,
  parameter int unsigned BIT_DEPTH       = 8,
  parameter int unsigned CLOCKS_PER_BAUD = 50,
  parameter int unsigned READ_LATENCY    = 2
) (
  input  logic                                clk_in,
  input  logic                                rst_in_n,
  input  logic                                start_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]     read_addr_out,
  output logic                                read_en_out,
  input  logic [BIT_DEPTH-1:0]                pixel_in,
  output logic                                tx_out,
  output logic                                busy_out,
  output logic                                done_out
);

  localparam int unsigned NumPixels = WIDTH * HEIGHT;
  localparam int unsigned AddrW     = $clog2(NumPixels);
  localparam int unsigned BaudW     = $clog2(CLOCKS_PER_BAUD);

  localparam logic [AddrW-1:0] LastAddr = AddrW'(NumPixels - 1);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLOCKS_PER_BAUD - 1);
  localparam logic [BaudW-1:0] LatchAt  = BaudW'(READ_LATENCY);

`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StFetch, StStart, StData, StStop, StDone, StChk} state_e;
`else
  typedef enum logic [2:0] {StIdle, StFetch, StStart, StData, StStop, StDone} state_e;
`endif

  state_e           state_q;
  logic [BaudW-1:0] baud_q;
  logic [3:0]       bit_q;
  logic [7:0]       shift_q;
  logic             more_q;
`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
  logic [7:0]       sum_q;
`endif

  logic       baud_end;
  logic [7:0] pixel_byte;

  assign baud_end = (baud_q == BaudLast);
  // Narrow pixels occupy the byte MSBs, low bits zero.
  assign pixel_byte = 8'(pixel_in) << (8 - BIT_DEPTH);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q       <= StIdle;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      more_q        <= 1'b0;
      read_addr_out <= '0;
      read_en_out   <= 1'b0;
      tx_out        <= 1'b1;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      read_en_out <= 1'b0;
      done_out    <= 1'b0;
      // Baud counter doubles as the read-latency timer in FETCH and STOP.
      baud_q      <= baud_end ? '0 : baud_q + BaudW'(1);

      case (state_q)
        StIdle: begin
          baud_q <= '0;
          if (start_in) begin
            state_q       <= StFetch;
            busy_out      <= 1'b1;
            read_en_out   <= 1'b1;
            read_addr_out <= '0;
`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
            sum_q         <= '0;
`endif
          end
        end

        StFetch: begin
          if (baud_q == LatchAt) begin
            shift_q <= pixel_byte;
`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
            sum_q   <= sum_q + pixel_byte;
`endif
            tx_out  <= 1'b0;
            baud_q  <= '0;
            state_q <= StStart;
          end
        end

        StStart: begin
          if (baud_end) begin
            tx_out  <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
            state_q <= StData;
          end
        end

        StData: begin
          if (baud_end) begin
            if (bit_q == 4'd7) begin
              tx_out  <= 1'b1;
              state_q <= StStop;
              // Prefetch the next pixel while the stop bit is on the line.
              if (read_addr_out != LastAddr) begin
                read_addr_out <= read_addr_out + AddrW'(1);
                read_en_out   <= 1'b1;
                more_q        <= 1'b1;
              end else begin
                more_q <= 1'b0;
              end
            end else begin
              tx_out  <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 4'd1;
            end
          end
        end

        StStop: begin
          if (more_q && (baud_q == LatchAt)) begin
            shift_q <= pixel_byte;
`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
            sum_q   <= sum_q + pixel_byte;
`endif
          end
          if (baud_end) begin
            if (more_q) begin
              tx_out  <= 1'b0;
              state_q <= StStart;
            end else begin
`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
              tx_out  <= 1'b0;
              shift_q <= sum_q;
              bit_q   <= '0;
              state_q <= StChk;
`else
              done_out <= 1'b1;
              busy_out <= 1'b0;
              state_q  <= StDone;
`endif
            end
          end
        end

`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
        // Whole checksum byte in one state: bit_q 0..7 data, 8 stop, 9 end of frame.
        StChk: begin
          if (baud_end) begin
            if (bit_q == 4'd9) begin
              done_out <= 1'b1;
              busy_out <= 1'b0;
              state_q  <= StDone;
            end else begin
              tx_out  <= (bit_q == 4'd8) ? 1'b1 : shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 4'd1;
            end
          end
        end
`endif

        StDone: begin
          baud_q  <= '0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_uart_streamer.sv
// Directed bench for bram_uart_streamer: UART decode of whole frames, timing, start/reset corners.
module tb_bram_uart_streamer;

  localparam int Cpb = 8;
`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
  localparam int ExtraBytes = 1;
`else
  localparam int ExtraBytes = 0;
`endif

  logic clk_100mhz = 1'b0;
  logic rst_n      = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // 8-bit instance: 4x2 frame
  logic       start8;
  logic [2:0] addr8;
  logic       rd_en8;
  logic [7:0] pix8;
  logic       tx8, busy8, done8;

  bram_uart_streamer #(
    .WIDTH(4), .HEIGHT(2), .BIT_DEPTH(8), .CLOCKS_PER_BAUD(Cpb), .READ_LATENCY(2)
  ) u_dut8 (
    .clk_in(clk_100mhz), .rst_in_n(rst_n), .start_in(start8), .read_addr_out(addr8),
    .read_en_out(rd_en8), .pixel_in(pix8), .tx_out(tx8), .busy_out(busy8), .done_out(done8)
  );

  // 4-bit instance: 2x1 frame
  logic       start4;
  logic [0:0] addr4;
  logic       rd_en4;
  logic [3:0] pix4;
  logic       tx4, busy4, done4;

  bram_uart_streamer #(
    .WIDTH(2), .HEIGHT(1), .BIT_DEPTH(4), .CLOCKS_PER_BAUD(Cpb), .READ_LATENCY(2)
  ) u_dut4 (
    .clk_in(clk_100mhz), .rst_in_n(rst_n), .start_in(start4), .read_addr_out(addr4),
    .read_en_out(rd_en4), .pixel_in(pix4), .tx_out(tx4), .busy_out(busy4), .done_out(done4)
  );

  // Latency-2 BRAM models; data is valid for exactly one cycle, junk otherwise.
  logic [7:0] mem8 [8] = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFF, 8'h80, 8'h7E, 8'h03};
  logic [3:0] mem4 [2] = '{4'hF, 4'h3};
  logic       v8, v4;
  logic [7:0] s8;
  logic [3:0] s4;

  always @(posedge clk_100mhz) begin
    v8   <= rd_en8;
    s8   <= mem8[addr8];
    pix8 <= v8 ? s8 : 8'h5A;
    v4   <= rd_en4;
    s4   <= mem4[addr4];
    pix4 <= v4 ? s4 : 4'h5;
  end

  logic [2:0] addr_log[$];
  always @(negedge clk_100mhz) if (rd_en8 === 1'b1) addr_log.push_back(addr8);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx4 : tx8;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy4 : busy8;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel != 0) ? done4 : done8;
  endfunction
  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start4 = v;
    else start8 = v;
  endtask

  logic [7:0] rx [16];
  int   rx_n, glitches, first_cyc, start_cyc, done_lat;
  logic done_seen, busy_after, done_next, timed_out;
  logic aborted, abort_tx, abort_busy, abort_en;

  // Pulses start, then decodes nbytes frames sample-by-sample; any start bit not low at its
  // first sample (including an idle gap) counts as a glitch.
  task automatic run_frame(input int sel, input int nbytes, input int inject_at,
                           input int abort_at);
    int         wait_n;
    logic       bit_v;
    logic [7:0] byt;
    rx_n = 0; glitches = 0; timed_out = 1'b0; aborted = 1'b0;
    done_seen = 1'b0; busy_after = 1'b1; done_next = 1'b1; done_lat = 0;
    @(negedge clk_100mhz);
    set_start(sel, 1'b1);
    start_cyc = cyc;
    @(negedge clk_100mhz);
    set_start(sel, 1'b0);
    wait_n = 0;
    while (tx_of(sel) !== 1'b0 && wait_n < 100) begin
      @(negedge clk_100mhz);
      wait_n++;
    end
    if (tx_of(sel) !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    first_cyc = cyc;
    for (int k = 0; k < nbytes; k++) begin
      for (int j = 0; j < Cpb; j++) begin
        if (tx_of(sel) !== 1'b0) glitches++;
        if (k == inject_at) set_start(sel, j == 0);
        @(negedge clk_100mhz);
      end
      for (int b = 0; b < 8; b++) begin
        bit_v = tx_of(sel);
        for (int j = 0; j < Cpb; j++) begin
          if (k == abort_at && b == 2 && j == 3) begin
            #2 rst_n = 1'b0;
            #1 abort_tx = tx_of(sel);
            abort_busy = busy_of(sel);
            abort_en   = rd_en8;
            aborted    = 1'b1;
            return;
          end
          if (tx_of(sel) !== bit_v) glitches++;
          @(negedge clk_100mhz);
        end
        byt[b] = bit_v;
      end
      for (int j = 0; j < Cpb; j++) begin
        if (tx_of(sel) !== 1'b1) glitches++;
        @(negedge clk_100mhz);
      end
      rx[k] = byt;
      rx_n++;
    end
    done_seen  = done_of(sel);
    busy_after = busy_of(sel);
    done_lat   = cyc - first_cyc;
    @(negedge clk_100mhz);
    done_next = done_of(sel);
  endtask

  task automatic check_frame(input string tag, input int sel, input int npix);
    logic [7:0] e;
    logic [7:0] sum;
    sum = 8'h00;
    check({tag, "_timeout"}, timed_out, 1'b0);
    check({tag, "_start_latency"}, first_cyc - start_cyc, 4);
    check({tag, "_glitch_or_gap"}, glitches, 0);
    check({tag, "_byte_count"}, rx_n, npix + ExtraBytes);
    for (int k = 0; k < npix; k++) begin
      e = (sel != 0) ? {mem4[k], 4'h0} : mem8[k];
      check($sformatf("%s_byte%0d", tag, k), rx[k], e);
      sum = sum + e;
    end
`ifdef BRAM_UART_STREAMER_CHECKSUM_EN
    check({tag, "_checksum"}, rx[npix], sum);
`endif
    check({tag, "_done_pulse"}, done_seen, 1'b1);
    check({tag, "_done_latency"}, done_lat, (npix + ExtraBytes) * 10 * Cpb);
    check({tag, "_busy_drop"}, busy_after, 1'b0);
    check({tag, "_done_one_cycle"}, done_next, 1'b0);
  endtask

  task automatic check_reads(input string tag);
    int bad;
    bad = 0;
    check({tag, "_read_count"}, addr_log.size(), 8);
    foreach (addr_log[i]) if (addr_log[i] !== 3'(i)) bad++;
    check({tag, "_read_order"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    start8 = 1'b0;
    start4 = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    check("rst_tx", tx8, 1'b1);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_read_en", rd_en8, 1'b0);
    check("rst_addr", addr8, 3'd0);
    check("rst_tx4", tx4, 1'b1);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk_100mhz);
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || rd_en8 !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);

    addr_log.delete();
    run_frame(0, 8 + ExtraBytes, -1, -1);
    check_frame("f1", 0, 8);
    check_reads("f1");

    // Start pulsed during byte 3 must be dropped.
    addr_log.delete();
    run_frame(0, 8 + ExtraBytes, 3, -1);
    check_frame("f2", 0, 8);
    repeat (30) @(negedge clk_100mhz);
    check("f2_no_requeue_busy", busy8, 1'b0);
    check("f2_no_requeue_tx", tx8, 1'b1);
    check_reads("f2");

    // Asynchronous reset in the middle of byte 5.
    run_frame(0, 8 + ExtraBytes, -1, 5);
    check("f3_aborted", aborted, 1'b1);
    check("f3_abort_tx", abort_tx, 1'b1);
    check("f3_abort_busy", abort_busy, 1'b0);
    check("f3_abort_read_en", abort_en, 1'b0);
    repeat (2) @(negedge clk_100mhz);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_100mhz);
    check("f3_idle_after_reset", busy8, 1'b0);

    addr_log.delete();
    run_frame(0, 8 + ExtraBytes, -1, -1);
    check_frame("f4", 0, 8);
    check_reads("f4");

    run_frame(1, 2 + ExtraBytes, -1, -1);
    check_frame("d4", 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
